// File: rtl/pwqe_station_buffer_if.sv
// Bundle of the ingress, scheduler, release and status signals of the PWQE
// station buffer. The master side drives the strobes; the buffer is the slave.
interface pwqe_station_buffer_if #(
    parameter int unsigned WQE_WIDTH           = 512,
    parameter int unsigned PWQE_SLOT_NUM       = 4,
    parameter int unsigned PWQE_BUF_ADDR_WIDTH = 2,
    parameter int unsigned PWQE_BUF_WIDTH      = 512
);
    logic                             i_bs_wqe_val;
    logic                             o_bs_wqe_rdy;
    logic [WQE_WIDTH-1:0]             i_bs_wqe;
    logic                             i_ren_1;
    logic                             i_wen_1;
    logic [PWQE_BUF_ADDR_WIDTH-1:0]   i_addr_1;
    logic [PWQE_BUF_WIDTH-1:0]        i_din_1;
    logic [PWQE_BUF_WIDTH-1:0]        o_dout_1;
    logic [PWQE_SLOT_NUM-1:0]         o_slot_status;
    logic                             i_slot_free;
    logic [PWQE_BUF_ADDR_WIDTH-1:0]   i_slot_free_addr;
    logic [PWQE_BUF_ADDR_WIDTH:0]     o_free_cnt;
    logic                             o_err;

    modport master (
        output i_bs_wqe_val, i_bs_wqe, i_ren_1, i_wen_1, i_addr_1, i_din_1,
               i_slot_free, i_slot_free_addr,
        input  o_bs_wqe_rdy, o_dout_1, o_slot_status, o_free_cnt, o_err
    );

    modport slave (
        input  i_bs_wqe_val, i_bs_wqe, i_ren_1, i_wen_1, i_addr_1, i_din_1,
               i_slot_free, i_slot_free_addr,
        output o_bs_wqe_rdy, o_dout_1, o_slot_status, o_free_cnt, o_err
    );
endinterface

// File: rtl/pwqe_station_buffer.sv
// PWQE station buffer: slot store in front of the group scheduler. Each slot
// cycles FREE -> READY -> BUSY -> (READY | FREE). Read data has 1-cycle latency.
// Optional macro STATION_BUF_ERR_EN builds the sticky illegal-access flag o_err.
module pwqe_station_buffer #(
    parameter int unsigned WQE_WIDTH           = 512,
    parameter int unsigned PWQE_SLOT_NUM       = 4,
    parameter int unsigned PWQE_BUF_ADDR_WIDTH = 2,
    parameter int unsigned PWQE_BUF_WIDTH      = 512
) (
    input logic                  clk,
    input logic                  rst,
    pwqe_station_buffer_if.slave bus
);
    localparam int unsigned AW = PWQE_BUF_ADDR_WIDTH;
    localparam int unsigned CW = PWQE_BUF_ADDR_WIDTH + 1;

    localparam logic [1:0] ST_FREE  = 2'b00;
    localparam logic [1:0] ST_READY = 2'b01;
    localparam logic [1:0] ST_BUSY  = 2'b10;

    logic [1:0]                state_q [PWQE_SLOT_NUM];
    logic [1:0]                state_d [PWQE_SLOT_NUM];
    logic [PWQE_BUF_WIDTH-1:0] mem_q   [PWQE_SLOT_NUM];
    logic [PWQE_BUF_WIDTH-1:0] dout_q;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [AW-1:0]             alloc_idx;
    logic                      any_free;
    logic                      alloc_fire;
    logic                      rel_fire;

    // Lowest-index FREE slot, picked from registered state only.
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        for (int i = int'(PWQE_SLOT_NUM) - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                any_free  = 1'b1;
                alloc_idx = AW'(i);
            end
        end
    end

    assign alloc_fire = bus.i_bs_wqe_val && any_free;
    assign rel_fire   = bus.i_slot_free && (state_q[bus.i_slot_free_addr] != ST_FREE);

    // Per-slot next state; later assignments win: release > write-back > read > allocate.
    always_comb begin
        for (int i = 0; i < int'(PWQE_SLOT_NUM); i++) begin
            state_d[i] = state_q[i];
            if (alloc_fire && alloc_idx == AW'(i)) begin
                state_d[i] = ST_READY;
            end
            // A same-cycle write-back owns the state, so the read must not claim the slot.
            if (bus.i_ren_1 && !bus.i_wen_1 && bus.i_addr_1 == AW'(i)
                && state_q[i] == ST_READY) begin
                state_d[i] = ST_BUSY;
            end
            if (bus.i_wen_1 && bus.i_addr_1 == AW'(i) && state_q[i] == ST_BUSY) begin
                state_d[i] = ST_READY;
            end
            if (rel_fire && bus.i_slot_free_addr == AW'(i)) begin
                state_d[i] = ST_FREE;
            end
        end
    end

    // FREE count moves by +release -allocate; both at once leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q + CW'(rel_fire) - CW'(alloc_fire);
    end

    // Slot state, free count and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PWQE_SLOT_NUM); i++) begin
                state_q[i] <= ST_FREE;
            end
            cnt_q  <= CW'(PWQE_SLOT_NUM);
            dout_q <= '0;
        end else begin
            for (int i = 0; i < int'(PWQE_SLOT_NUM); i++) begin
                state_q[i] <= state_d[i];
            end
            cnt_q <= cnt_d;
            if (bus.i_ren_1) begin
                dout_q <= mem_q[bus.i_addr_1];
            end
        end
    end

    // Slot memory, not reset; an ingress handshake during reset is dropped.
    always_ff @(posedge clk) begin
        if (bus.i_wen_1) begin
            mem_q[bus.i_addr_1] <= bus.i_din_1;
        end
        if (alloc_fire && !rst) begin
            mem_q[alloc_idx] <= PWQE_BUF_WIDTH'(bus.i_bs_wqe);
        end
    end

`ifdef STATION_BUF_ERR_EN
    logic err_q;
    logic err_set;

    // Illegal accesses. Read and write share i_addr_1, so they can never target
    // different slots and that case needs no term here.
    always_comb begin
        err_set = 1'b0;
        if (bus.i_ren_1 && state_q[bus.i_addr_1] != ST_READY) begin
            err_set = 1'b1;
        end
        if (bus.i_wen_1 && state_q[bus.i_addr_1] != ST_BUSY) begin
            err_set = 1'b1;
        end
        if (bus.i_slot_free && state_q[bus.i_slot_free_addr] == ST_FREE) begin
            err_set = 1'b1;
        end
    end

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

    // READY bitmap for the scheduler.
    always_comb begin
        for (int i = 0; i < int'(PWQE_SLOT_NUM); i++) begin
            bus.o_slot_status[i] = (state_q[i] == ST_READY);
        end
    end

    assign bus.o_bs_wqe_rdy = any_free;
    assign bus.o_dout_1     = dout_q;
    assign bus.o_free_cnt   = cnt_q;
endmodule

// File: tb/tb_pwqe_station_buffer.sv
// Directed table-driven bench for pwqe_station_buffer plus a hand-written
// fill/readback sequence. Error expectations follow STATION_BUF_ERR_EN.
module tb_pwqe_station_buffer;
`ifdef STATION_BUF_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        val;
        logic [15:0] wqe;
        logic        ren;
        logic        wen;
        logic [1:0]  addr;
        logic [15:0] din;
        logic        fr;
        logic [1:0]  fa;
        logic        e_rdy;
        logic [3:0]  e_st;
        logic [2:0]  e_cnt;
        logic [15:0] e_dout;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t v [28];

    always #5 clk = ~clk;

    pwqe_station_buffer_if bus ();

    pwqe_station_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(logic r, logic va, logic [15:0] w, logic re, logic we,
                                logic [1:0] a, logic [15:0] d, logic f, logic [1:0] fad,
                                logic rdy, logic [3:0] st, logic [2:0] cnt,
                                logic [15:0] dout, logic err);
        vec_t t;
        t.rst = r;    t.val = va;   t.wqe = w;     t.ren = re;  t.wen = we;
        t.addr = a;   t.din = d;    t.fr = f;      t.fa = fad;
        t.e_rdy = rdy; t.e_st = st; t.e_cnt = cnt; t.e_dout = dout; t.e_err = err;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [511:0] act, logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        rst                  = t.rst;
        bus.i_bs_wqe_val     = t.val;
        bus.i_bs_wqe         = 512'(t.wqe);
        bus.i_ren_1          = t.ren;
        bus.i_wen_1          = t.wen;
        bus.i_addr_1         = t.addr;
        bus.i_din_1          = 512'(t.din);
        bus.i_slot_free      = t.fr;
        bus.i_slot_free_addr = t.fa;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        int acc;
        //           rst val wqe     ren wen ad din     fr fa  rdy st       cnt dout    err
        v[0]  = mk(1, 0, 16'h00, 0, 0, 0, 16'h00, 0, 0, 1, 4'b0000, 4, 16'h00, 0);
        v[1]  = mk(0, 1, 16'hA0, 0, 0, 0, 16'h00, 0, 0, 1, 4'b0001, 3, 16'h00, 0);
        v[2]  = mk(0, 1, 16'hA1, 0, 0, 0, 16'h00, 0, 0, 1, 4'b0011, 2, 16'h00, 0);
        v[3]  = mk(0, 1, 16'hA2, 0, 0, 0, 16'h00, 0, 0, 1, 4'b0111, 1, 16'h00, 0);
        v[4]  = mk(0, 1, 16'hA3, 0, 0, 0, 16'h00, 0, 0, 0, 4'b1111, 0, 16'h00, 0);
        v[5]  = mk(0, 1, 16'hA4, 0, 0, 0, 16'h00, 0, 0, 0, 4'b1111, 0, 16'h00, 0);
        v[6]  = mk(0, 1, 16'hA4, 1, 0, 2, 16'h00, 0, 0, 0, 4'b1011, 0, 16'hA2, 0);
        v[7]  = mk(0, 1, 16'hA4, 0, 1, 2, 16'hB2, 0, 0, 0, 4'b1111, 0, 16'hA2, 0);
        v[8]  = mk(0, 1, 16'hA4, 1, 0, 2, 16'h00, 0, 0, 0, 4'b1011, 0, 16'hB2, 0);
        v[9]  = mk(0, 1, 16'hA4, 0, 1, 2, 16'hB2, 0, 0, 0, 4'b1111, 0, 16'hB2, 0);
        v[10] = mk(0, 1, 16'hA4, 0, 0, 0, 16'h00, 1, 1, 1, 4'b1101, 1, 16'hB2, 0);
        v[11] = mk(0, 1, 16'hA4, 0, 0, 0, 16'h00, 0, 0, 0, 4'b1111, 0, 16'hB2, 0);
        v[12] = mk(0, 0, 16'h00, 1, 0, 1, 16'h00, 0, 0, 0, 4'b1101, 0, 16'hA4, 0);
        v[13] = mk(0, 0, 16'h00, 1, 0, 3, 16'h00, 0, 0, 0, 4'b0101, 0, 16'hA3, 0);
        v[14] = mk(0, 0, 16'h00, 0, 1, 3, 16'hC3, 1, 3, 1, 4'b0101, 1, 16'hA3, 0);
        v[15] = mk(0, 0, 16'h00, 1, 1, 0, 16'hD0, 0, 0, 1, 4'b0101, 1, 16'hA0, 1);
        v[16] = mk(0, 0, 16'h00, 1, 0, 0, 16'h00, 0, 0, 1, 4'b0100, 1, 16'hD0, 1);
        v[17] = mk(0, 0, 16'h00, 1, 0, 2, 16'h00, 1, 2, 1, 4'b0000, 2, 16'hB2, 1);
        v[18] = mk(1, 1, 16'hEE, 0, 0, 0, 16'h00, 0, 0, 1, 4'b0000, 4, 16'h00, 0);
        v[19] = mk(0, 0, 16'h00, 1, 0, 3, 16'h00, 0, 0, 1, 4'b0000, 4, 16'hC3, 1);
        v[20] = mk(0, 0, 16'h00, 1, 0, 2, 16'h00, 0, 0, 1, 4'b0000, 4, 16'hB2, 1);
        v[21] = mk(0, 0, 16'h00, 0, 0, 0, 16'h00, 0, 0, 1, 4'b0000, 4, 16'hB2, 1);
        v[22] = mk(0, 1, 16'hF0, 0, 0, 0, 16'h00, 0, 0, 1, 4'b0001, 3, 16'hB2, 1);
        v[23] = mk(0, 1, 16'hF1, 0, 0, 0, 16'h00, 1, 0, 1, 4'b0010, 3, 16'hB2, 1);
        v[24] = mk(0, 0, 16'h00, 1, 0, 1, 16'h00, 0, 0, 1, 4'b0000, 3, 16'hF1, 1);
        v[25] = mk(0, 1, 16'hF2, 0, 0, 0, 16'h00, 0, 0, 1, 4'b0001, 2, 16'hF1, 1);
        v[26] = mk(0, 0, 16'h00, 1, 0, 0, 16'h00, 0, 0, 1, 4'b0000, 2, 16'hF2, 1);
        v[27] = mk(0, 0, 16'h00, 0, 0, 0, 16'h00, 1, 3, 1, 4'b0000, 2, 16'hF2, 1);

        idle();
        rst = 1'b1;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            drive(v[k]);
            @(posedge clk);
            #1;
            chk("rdy",    k, 512'(bus.o_bs_wqe_rdy),  512'(v[k].e_rdy));
            chk("status", k, 512'(bus.o_slot_status), 512'(v[k].e_st));
            chk("cnt",    k, 512'(bus.o_free_cnt),    512'(v[k].e_cnt));
            chk("dout",   k, bus.o_dout_1,            512'(v[k].e_dout));
            chk("err",    k, 512'(bus.o_err),         512'(ErrEn & v[k].e_err));
        end

        // Fill from reset with val held, bounded; exactly four must be accepted.
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            bus.i_bs_wqe_val = 1'b1;
            bus.i_bs_wqe     = 512'(16'h100 + acc);
            if (bus.o_bs_wqe_rdy) acc++;
            @(negedge clk);
        end
        idle();
        chk("fill_acc", 100, 512'(acc), 512'(4));
        chk("fill_cnt", 100, 512'(bus.o_free_cnt), 512'(0));
        chk("fill_rdy", 100, 512'(bus.o_bs_wqe_rdy), 512'(0));
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            bus.i_ren_1  = 1'b1;
            bus.i_addr_1 = 2'(s);
            @(posedge clk);
            #1;
            chk("fill_data", 101 + s, bus.o_dout_1, 512'(16'h100 + s));
        end
        @(negedge clk);
        idle();
        chk("fill_status", 105, 512'(bus.o_slot_status), 512'(4'b0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
